apb_master_bridge: RTL and testbench



---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_master_bridge.sv | 171 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
// Optional feature macro: APB_TIMEOUT_EN (ACCESS-phase timeout).
package apb_pkg;

  localparam int unsigned APB_AW = 12;
  localparam int unsigned APB_DW = 32;

  // Low address bits that must be zero for a word-aligned transfer
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB initiator, one transfer outstanding.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYC cycles for pready.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned AW          = APB_AW,
  parameter int unsigned DW          = APB_DW,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          psel,
  output logic          penable,
  output logic [AW-1:0] paddr,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  input  logic          pready,
  input  logic [DW-1:0] prdata,
  input  logic          pslverr
);

  apb_state_e    state_q, state_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          accept;
  logic          timeout;

  // Accept only when idle and any pending response is drained on this edge
  assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_REQ_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W     = (CNT_REQ_W > 32'd8) ? CNT_REQ_W : 32'd8;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Count ACCESS cycles that end without pready; abort on the last allowed one
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  assign timeout = (state_q == ACCESS) && !pready &&
                   ((wait_cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^32'(TIMEOUT_CYC);
  assign timeout           = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_aligned(cmd_addr[1:0])) begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            if (cmd_write) begin
              pwdata_d = cmd_wdata;
            end
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (timeout) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed cases plus randomized traffic
// against a transaction-timeline model with an APB slave memory.
module tb_apb_master_bridge;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  always #5 clk = ~clk;

  apb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  int total = 0;
  int bad   = 0;

  // Slave memory and stimulus knobs
  logic [DW-1:0] mem [0:1023];
  bit            rand_mode = 1'b0;
  int            slv_wait  = 0;
  bit            slv_err   = 1'b0;
  bit            drv_valid = 1'b0;
  bit            drv_write = 1'b0;
  logic [AW-1:0] drv_addr  = '0;
  logic [DW-1:0] drv_wdata = '0;
  bit            drv_rsp_ready = 1'b1;

  // Model: in-flight transfer timeline and pending response
  bit            m_busy = 1'b0;
  int            m_age = 0;      // cycles since accept (1 = setup cycle)
  int            m_waits = 0;    // access cycles that ended without pready
  logic [AW-1:0] m_paddr = '0;
  bit            m_pwrite = 1'b0;
  logic [DW-1:0] m_pwdata = '0;
  bit            m_rv = 1'b0;
  bit            m_re = 1'b0;
  logic [DW-1:0] m_rd = '0;
  bit            m_acc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_waits = 0;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
    m_rv = 1'b0; m_re = 1'b0; m_rd = '0; m_acc = 1'b0;
  endtask

  // One clock cycle: compare outputs, drive inputs, advance the model across the next edge
  task automatic step();
    bit pen_e, ready_e, acc, done, tmo;
    @(negedge clk);
    pen_e = m_busy && (m_age >= 2);
    check("psel", 64'(psel), 64'(m_busy));
    check("penable", 64'(penable), 64'(pen_e));
    check("paddr", 64'(paddr), 64'(m_paddr));
    check("pwrite", 64'(pwrite), 64'(m_pwrite));
    check("pwdata", 64'(pwdata), 64'(m_pwdata));
    check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    check("rsp_rdata", 64'(rsp_rdata), 64'(m_rd));
    check("rsp_err", 64'(rsp_err), 64'(m_re));

    cmd_valid = drv_valid;
    cmd_write = drv_write;
    cmd_addr  = drv_addr;
    cmd_wdata = drv_wdata;
    rsp_ready = drv_rsp_ready;
    if (pen_e) begin
      pready  = (m_waits >= slv_wait);
      prdata  = mem[m_paddr[11:2]];
      pslverr = slv_err;
    end else if (rand_mode) begin
      pready  = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
    end else begin
      pready  = 1'b0;
      prdata  = '0;
      pslverr = 1'b0;
    end
    #1;
    ready_e = !m_busy && (!m_rv || rsp_ready);
    check("cmd_ready", 64'(cmd_ready), 64'(ready_e));

    acc  = cmd_valid && ready_e;
    done = pen_e && pready;
    tmo  = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo = pen_e && !pready && (m_waits + 1 == TO);
`endif
    if (m_rv && rsp_ready) m_rv = 1'b0;
    if (done) begin
      m_busy = 1'b0;
      m_rv   = 1'b1;
      m_re   = pslverr;
      m_rd   = m_pwrite ? '0 : prdata;
      if (m_pwrite && !pslverr) mem[m_paddr[11:2]] = m_pwdata;
    end else if (tmo) begin
      m_busy = 1'b0;
      m_rv   = 1'b1;
      m_re   = 1'b1;
      m_rd   = '0;
    end else if (m_busy) begin
      if (pen_e) m_waits++;
      m_age++;
    end
    m_acc = acc;
    if (acc) begin
      if (cmd_addr[1:0] != 2'b00) begin
        m_rv = 1'b1;
        m_re = 1'b1;
        m_rd = '0;
      end else begin
        m_busy  = 1'b1;
        m_age   = 1;
        m_waits = 0;
        m_paddr = cmd_addr;
        m_pwrite = cmd_write;
        if (cmd_write) m_pwdata = cmd_wdata;
        if (rand_mode) begin
          slv_wait = $urandom_range(0, 3);
          slv_err  = ($urandom_range(0, 5) == 0);
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drv_valid = 1'b1; drv_write = w; drv_addr = a; drv_wdata = d;
    step();
    drv_valid = 1'b0;
  endtask

  task automatic rand_drive();
    if (!drv_valid || m_acc) begin
      drv_valid = ($urandom_range(0, 9) < 6);
      drv_write = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        drv_addr = {10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
      else
        drv_addr = {10'($urandom_range(0, 1023)), 2'b00};
      drv_wdata = $urandom;
    end
    drv_rsp_ready = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5000_0000 + 32'(i);
    mem[1023] = 32'h1234_5678;
    mem[4]    = 32'hDEAD_BEEF;

    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    #12;
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #2 rstn = 1'b1;

    // Zero-wait write
    send(1'b1, 12'h000, 32'hA5A5_5A5A);
    step();
    check("t1_psel", 64'(psel), 64'd1);
    check("t1_penable_setup", 64'(penable), 64'd0);
    check("t1_pwdata", 64'(pwdata), 64'hA5A5_5A5A);
    step();
    check("t1_penable_access", 64'(penable), 64'd1);
    step();
    check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t1_rsp_err", 64'(rsp_err), 64'd0);

    // Read with 3 wait states
    slv_wait = 3;
    send(1'b0, 12'hFFC, '0);
    steps(5);
    check("t2_rsp_early", 64'(rsp_valid), 64'd0);
    check("t2_paddr", 64'(paddr), 64'hFFC);
    step();
    check("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t2_rdata", 64'(rsp_rdata), 64'h1234_5678);
    slv_wait = 0;

    // Misaligned read
    send(1'b0, 12'h002, '0);
    step();
    check("t3_psel", 64'(psel), 64'd0);
    check("t3_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t3_rsp_err", 64'(rsp_err), 64'd1);
    check("t3_rdata", 64'(rsp_rdata), 64'd0);

    // Backpressure, then accept on the draining edge
    drv_rsp_ready = 1'b0;
    send(1'b1, 12'h020, 32'hCAFE_F00D);
    steps(3);
    drv_valid = 1'b1; drv_write = 1'b0; drv_addr = 12'h020;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_ready_blocked", 64'(cmd_ready), 64'd0);
      check("t4_rsp_held", 64'(rsp_valid), 64'd1);
    end
    drv_rsp_ready = 1'b1;
    step();
    check("t4_ready_drain", 64'(cmd_ready), 64'd1);
    drv_valid = 1'b0;
    steps(3);
    check("t4_read_back", 64'(rsp_rdata), 64'hCAFE_F00D);

    // Slave error on read keeps prdata
    slv_err = 1'b1;
    send(1'b0, 12'h010, '0);
    steps(3);
    check("t5_rsp_err", 64'(rsp_err), 64'd1);
    check("t5_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    slv_err = 1'b0;

    // Reset during ACCESS drops the transfer
    slv_wait = 5;
    send(1'b0, 12'h030, '0);
    steps(2);
    #2 rstn = 1'b0;
    #1;
    check("t6_psel", 64'(psel), 64'd0);
    check("t6_penable", 64'(penable), 64'd0);
    check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    model_reset();
    @(posedge clk); #2 rstn = 1'b1;
    steps(8);
    check("t6_no_rsp", 64'(rsp_valid), 64'd0);
    slv_wait = 0;

`ifdef APB_TIMEOUT_EN
    slv_wait = 1000;
    send(1'b0, 12'h040, '0);
    steps(17);
    check("t7_before_timeout", 64'(rsp_valid), 64'd0);
    step();
    check("t7_timeout_valid", 64'(rsp_valid), 64'd1);
    check("t7_timeout_err", 64'(rsp_err), 64'd1);
    slv_wait = 15;
    send(1'b0, 12'h040, '0);
    steps(18);
    check("t7_pready_wins", 64'(rsp_err), 64'd0);
    slv_wait = 0;
`endif

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      step();
    end
    rand_mode = 1'b0;
    drv_valid = 1'b0;
    drv_rsp_ready = 1'b1;
    steps(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
